collision_scan_ctrl: RTL and testbench
======================================

COLLISION_SCAN_CTRL -- requirements
Module: collision_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROBES, default 8, number of probe-point slots.
REQ-002 SHALL have parameter SIZE_CHECK, default 20, probe/check word width.
REQ-003 SHALL have parameter SIZE_REG, default 32, comparator result width.
REQ-004 SHALL have parameter SETTLE, default 1 (range 1..15), cycles check is held before refresh.
REQ-005 SHALL have port: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: start  in  1  begin scan, sampled only in IDLE.
REQ-008 SHALL have port: abort  in  1  cancel scan, returns to IDLE.
REQ-009 SHALL have port: probe_we  in  1  write strobe, probe table.
REQ-010 SHALL have port: probe_addr  in  clog2(NUM_PROBES)  probe slot index.
REQ-011 SHALL have port: probe_data  in  SIZE_CHECK  probe point to store.
REQ-012 SHALL have port: probe_count  in  clog2(NUM_PROBES)+1  probes per scan, sampled at start.
REQ-013 SHALL have port: check  out  SIZE_CHECK  registered point driven to the sprite comparator array.
REQ-014 SHALL have port: refresh  out  1  registered one-cycle capture strobe to the comparator array.
REQ-015 SHALL have port: cmp_result  in  SIZE_REG  registered hit bitmask returned by the comparator array.
REQ-016 SHALL have port: hit_mask  out  SIZE_REG  OR of all probe results; bit SIZE_REG-1 always 0.
REQ-017 SHALL have port: probe_hits  out  NUM_PROBES  bit i set when probe i hit any sprite.
REQ-018 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-019 SHALL have port: done  out  1  one-cycle pulse at scan completion.
REQ-020 SHALL have port: result_valid  out  1  level; high from done until next accepted start or reset.

Function
REQ-021 SHALL implement states IDLE, SETUP, STROBE, CAPTURE, FINISH.
REQ-022 In IDLE, start=1 and abort=0 SHALL latch N=min(probe_count,NUM_PROBES), clear hit_mask, probe_hits and result_valid, set index 0, go to SETUP; N=0 SHALL go directly to FINISH.
REQ-023 On SETUP entry, check SHALL take probe[index]; SETUP SHALL last exactly SETTLE cycles, then go to STROBE.
REQ-024 STROBE SHALL last one cycle with refresh=1; refresh SHALL be 0 in every other state.
REQ-025 CAPTURE SHALL last one cycle: hit_mask |= cmp_result with bit SIZE_REG-1 forced 0; probe_hits[index] = |cmp_result[SIZE_REG-2:0].
REQ-026 After CAPTURE, index<N-1 SHALL increment index and go to SETUP; otherwise go to FINISH.
REQ-027 FINISH SHALL last one cycle with done=1, set result_valid, return to IDLE.
REQ-028 Latency: start sampled at edge k gives done=1 in cycle k+1+N*(SETTLE+2); N=0 gives done in cycle k+1.
REQ-029 start while busy SHALL be ignored; no queuing.
REQ-030 probe_we SHALL write probe_data to probe[probe_addr] only in IDLE; writes while busy SHALL be dropped; probe_addr>=NUM_PROBES SHALL be dropped.
REQ-031 abort in any non-IDLE state SHALL go to IDLE next cycle, refresh=0, no done, result_valid stays 0; hit_mask/probe_hits hold partial values.
REQ-032 abort and start in the same IDLE cycle SHALL be a no-op.
REQ-033 check SHALL hold its last value in IDLE.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE and zero check, refresh, hit_mask, probe_hits, busy, done, result_valid, index and all probe slots, from any state.
REQ-035 reset SHALL take priority over start, abort and probe_we.

Structure
REQ-036 Package collision_pkg SHALL hold the state enumeration and the default values of SIZE_REG, SIZE_CHECK, NUM_PROBES.
REQ-037 Probe storage SHALL be sub-module collision_probe_regfile (sync write, async read, sync reset); FSM, counters and accumulators stay in collision_scan_ctrl.

Verification
REQ-038 SETTLE=1; probes 0x12345, 0x0ABCD; probe_count=2; cmp_result 0x00000005 then 0x80000002 -> hit_mask=0x00000007, probe_hits=0x03, done in cycle k+7, refresh high in cycles k+2 and k+5.
REQ-039 probe_count=0, start -> done in cycle k+1, hit_mask=0, probe_hits=0, result_valid=1.
REQ-040 probe_count=12, NUM_PROBES=8, cmp_result=0 -> exactly 8 refresh pulses, done in cycle k+25.
REQ-041 abort in the cycle after the 2nd refresh pulse of a 4-probe scan -> IDLE next cycle, no done, result_valid=0, no further refresh pulses.
REQ-042 probe_we to slot 0 with data 0xFFFFF during a scan, then rescan -> check shows the old slot-0 value; start while busy gives no restart.
REQ-043 reset asserted mid-CAPTURE -> all outputs 0 at the next edge; a following scan reads all probe slots as 0.

Source files
------------

// File: rtl/collision_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : collision_pkg                                                |
// | Description : Shared state encoding and default sizes for the collision    |
// |               probe scan controller.                                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package collision_pkg;

    localparam int c_DEF_SIZE_REG   = 32;
    localparam int c_DEF_SIZE_CHECK = 20;
    localparam int c_DEF_NUM_PROBES = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/collision_probe_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : collision_probe_regfile                                      |
// | Description : Probe-point table: synchronous write, asynchronous read.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module collision_probe_regfile
    import collision_pkg::*;
#(
    parameter int NUM_PROBES = c_DEF_NUM_PROBES,
    parameter int SIZE_CHECK = c_DEF_SIZE_CHECK
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [$clog2(NUM_PROBES)-1:0] waddr,
    input  logic [SIZE_CHECK-1:0]         wdata,
    input  logic [$clog2(NUM_PROBES)-1:0] raddr,
    output logic [SIZE_CHECK-1:0]         rdata
);

    logic [SIZE_CHECK-1:0] r_slot [NUM_PROBES];

    // Addresses past the last slot are silently dropped on write and read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROBES; i++) begin
                r_slot[i] <= '0;
            end
        end else if (we && (int'(waddr) < NUM_PROBES)) begin
            r_slot[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < NUM_PROBES) ? r_slot[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/collision_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : collision_scan_ctrl                                          |
// | Description : Walks the probe table through the sprite comparator array    |
// |               and accumulates per-probe and overall hit results.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module collision_scan_ctrl
    import collision_pkg::*;
#(
    parameter int NUM_PROBES = c_DEF_NUM_PROBES,
    parameter int SIZE_CHECK = c_DEF_SIZE_CHECK,
    parameter int SIZE_REG   = c_DEF_SIZE_REG,
    parameter int SETTLE     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          probe_we,
    input  logic [$clog2(NUM_PROBES)-1:0] probe_addr,
    input  logic [SIZE_CHECK-1:0]         probe_data,
    input  logic [$clog2(NUM_PROBES):0]   probe_count,
    output logic [SIZE_CHECK-1:0]         check,
    output logic                          refresh,
    input  logic [SIZE_REG-1:0]           cmp_result,
    output logic [SIZE_REG-1:0]           hit_mask,
    output logic [NUM_PROBES-1:0]         probe_hits,
    output logic                          busy,
    output logic                          done,
    output logic                          result_valid
);

    localparam int                c_IW           = $clog2(NUM_PROBES);
    localparam int                c_CW           = c_IW + 1;
    localparam logic [c_CW-1:0]   c_NP           = c_CW'(NUM_PROBES);
    localparam logic [3:0]        c_SETTLE_LAST  = 4'(SETTLE - 1);
    localparam logic [SIZE_REG-1:0] c_HIT_KEEP   = {1'b0, {(SIZE_REG-1){1'b1}}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_IW-1:0]        r_index;
    logic [c_CW-1:0]        r_num;
    logic [3:0]             r_settle_cnt;
    logic [SIZE_CHECK-1:0]  r_check;
    logic                   r_refresh;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_result_valid;
    logic [SIZE_REG-1:0]    r_hit_mask;
    logic [NUM_PROBES-1:0]  r_probe_hits;

    logic                   w_start_ok;
    logic                   w_last_probe;
    logic                   w_enter_setup;
    logic [c_IW-1:0]        w_index_nxt;
    logic [c_CW-1:0]        w_num_sel;
    logic [SIZE_CHECK-1:0]  w_probe_rd;
    logic                   w_refresh_nxt;
    logic                   w_done_nxt;
    logic                   w_busy_nxt;

    assign w_start_ok    = (r_state == S_IDLE) && start && !abort;
    assign w_num_sel     = (probe_count > c_NP) ? c_NP : probe_count;
    assign w_last_probe  = ({1'b0, r_index} + c_CW'(1)) >= r_num;
    assign w_enter_setup = (w_state_nxt == S_SETUP) && (r_state != S_SETUP);
    assign w_index_nxt   = (r_state == S_IDLE) ? '0 : r_index + c_IW'(1);

    // Table writes are only honoured while idle so a scan sees a stable table.
    collision_probe_regfile #(
        .NUM_PROBES (NUM_PROBES),
        .SIZE_CHECK (SIZE_CHECK)
    ) u_probe_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (probe_we && (r_state == S_IDLE)),
        .waddr (probe_addr),
        .wdata (probe_data),
        .raddr (w_index_nxt),
        .rdata (w_probe_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state != S_IDLE) && abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start_ok) w_state_nxt = (w_num_sel == '0) ? S_FINISH : S_SETUP;
                S_SETUP:   if (r_settle_cnt == c_SETTLE_LAST) w_state_nxt = S_STROBE;
                S_STROBE:  w_state_nxt = S_CAPTURE;
                S_CAPTURE: w_state_nxt = w_last_probe ? S_FINISH : S_SETUP;
                S_FINISH:  w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so they leave a flop edge-aligned.
    always_comb begin
        w_refresh_nxt = (w_state_nxt == S_STROBE);
        w_done_nxt    = (w_state_nxt == S_FINISH);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index        <= '0;
            r_num          <= '0;
            r_settle_cnt   <= '0;
            r_check        <= '0;
            r_refresh      <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_hit_mask     <= '0;
            r_probe_hits   <= '0;
        end else begin
            r_refresh    <= w_refresh_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
            r_settle_cnt <= ((r_state == S_SETUP) && (w_state_nxt == S_SETUP)) ?
                            r_settle_cnt + 4'd1 : 4'd0;
            if (w_start_ok) begin
                r_num          <= w_num_sel;
                r_index        <= '0;
                r_hit_mask     <= '0;
                r_probe_hits   <= '0;
                r_result_valid <= 1'b0;
            end
            if (w_enter_setup) begin
                r_check <= w_probe_rd;
                r_index <= w_index_nxt;
            end
            // The top comparator bit is reserved and never contributes a hit.
            if ((r_state == S_CAPTURE) && !abort) begin
                r_hit_mask            <= r_hit_mask | (cmp_result & c_HIT_KEEP);
                r_probe_hits[r_index] <= |cmp_result[SIZE_REG-2:0];
            end
            if (w_done_nxt) begin
                r_result_valid <= 1'b1;
            end
        end
    end

    assign check        = r_check;
    assign refresh      = r_refresh;
    assign hit_mask     = r_hit_mask;
    assign probe_hits   = r_probe_hits;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_collision_scan_ctrl                                       |
// | Description : Scoreboard bench for collision_scan_ctrl with a behavioural  |
// |               comparator-array stand-in.                                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_collision_scan_ctrl;

    localparam int NP     = 8;
    localparam int SC     = 20;
    localparam int SR     = 32;
    localparam int SETTLE = 1;

    typedef struct { logic [SC-1:0] chk; int cyc; } ref_t;
    typedef struct { logic [SR-1:0] hm; logic [NP-1:0] ph; int cyc; int nref; } done_t;

    logic          clk = 1'b0;
    logic          reset, start, abort, probe_we;
    logic [2:0]    probe_addr;
    logic [SC-1:0] probe_data;
    logic [3:0]    probe_count;
    logic [SC-1:0] check;
    logic          refresh;
    logic [SR-1:0] cmp_result;
    logic [SR-1:0] hit_mask;
    logic [NP-1:0] probe_hits;
    logic          busy, done, result_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nref_seen = 0;

    logic [SC-1:0] model [NP];
    logic [SR-1:0] dir_res [$];
    logic [SR-1:0] cmp_q   [$];
    ref_t          ref_q   [$];
    done_t         done_q  [$];

    collision_scan_ctrl #(
        .NUM_PROBES (NP),
        .SIZE_CHECK (SC),
        .SIZE_REG   (SR),
        .SETTLE     (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .probe_we     (probe_we),
        .probe_addr   (probe_addr),
        .probe_data   (probe_data),
        .probe_count  (probe_count),
        .check        (check),
        .refresh      (refresh),
        .cmp_result   (cmp_result),
        .hit_mask     (hit_mask),
        .probe_hits   (probe_hits),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the sprite comparator array: a registered function of check.
    function automatic logic [SR-1:0] fcmp(input logic [SC-1:0] c);
        if (c[2:0] == 3'b000) return '0;
        return {c[11:0], c} ^ 32'hC3A5_0F1E;
    endfunction

    always @(posedge clk) begin
        if (reset) cmp_result <= '0;
        else if (refresh) begin
            if (cmp_q.size() > 0) cmp_result <= cmp_q.pop_front();
            else                  cmp_result <= fcmp(check);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes refresh or done.
    always @(negedge clk) begin
        ref_t  re;
        done_t de;
        if (!reset) begin
            if (refresh) begin
                nref_seen++;
                if (ref_q.size() == 0) chk("refresh_unexpected", 64'(cyc), 64'(-1));
                else begin
                    re = ref_q.pop_front();
                    chk("refresh_check", 64'(check), 64'(re.chk));
                    chk("refresh_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 64'(cyc), 64'(-1));
                else begin
                    de = done_q.pop_front();
                    chk("hit_mask", 64'(hit_mask), 64'(de.hm));
                    chk("probe_hits", 64'(probe_hits), 64'(de.ph));
                    chk("done_cycle", 64'(cyc), 64'(de.cyc));
                    chk("result_valid", 64'(result_valid), 64'd1);
                    chk("refresh_count", 64'(nref_seen), 64'(de.nref));
                end
            end
        end
    end

    task automatic write_probe(input int a, input logic [SC-1:0] d);
        probe_we = 1'b1; probe_addr = 3'(a); probe_data = d;
        @(posedge clk); #1;
        probe_we = 1'b0;
        model[a] = d;
    endtask

    task automatic do_scan(input int cnt, input bit mess);
        int n, k, t;
        logic [SR-1:0] r, hm;
        logic [NP-1:0] ph;
        ref_t  re;
        done_t de;
        n  = (cnt > NP) ? NP : cnt;
        hm = '0; ph = '0;
        for (int i = 0; i < n; i++) begin
            r = (i < dir_res.size()) ? dir_res[i] : fcmp(model[i]);
            if (i < dir_res.size()) cmp_q.push_back(r);
            hm    = hm | (r & 32'h7FFF_FFFF);
            ph[i] = |r[SR-2:0];
        end
        dir_res.delete();
        probe_count = 4'(cnt); start = 1'b1; nref_seen = 0;
        @(posedge clk); #1;
        start = 1'b0; k = cyc;
        for (int i = 0; i < n; i++) begin
            re.chk = model[i]; re.cyc = k + SETTLE + i * (SETTLE + 2);
            ref_q.push_back(re);
        end
        de.hm = hm; de.ph = ph; de.cyc = k + n * (SETTLE + 2); de.nref = n;
        done_q.push_back(de);
        if (mess) begin
            // Restart attempt and table write while busy must both be ignored.
            @(negedge clk);
            start = 1'b1; probe_we = 1'b1; probe_addr = 3'd0; probe_data = 20'hFFFFF;
            @(negedge clk);
            start = 1'b0; probe_we = 1'b0;
        end
        for (t = 0; t < 400 && done_q.size() != 0; t++) @(negedge clk);
        if (done_q.size() != 0) begin
            total++; bad++;
            $display("FAIL scan_timeout: got pending=%0d expected 0", done_q.size());
            done_q.delete(); ref_q.delete(); cmp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_check"}, 64'(check), 64'd0);
        chk({tag, "_refresh"}, 64'(refresh), 64'd0);
        chk({tag, "_hit_mask"}, 64'(hit_mask), 64'd0);
        chk({tag, "_probe_hits"}, 64'(probe_hits), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, seen, cnt;
        logic h0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; probe_we = 1'b0;
        probe_addr = '0; probe_data = '0; probe_count = '0;
        for (int i = 0; i < NP; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-probe directed scan with explicit comparator responses.
        write_probe(0, 20'h12345);
        write_probe(1, 20'h0ABCD);
        dir_res.push_back(32'h0000_0005);
        dir_res.push_back(32'h8000_0002);
        do_scan(2, 1'b0);

        // Empty scan finishes immediately with cleared results.
        do_scan(0, 1'b0);

        // Oversized count clamps to the table size.
        for (int i = 0; i < NP; i++) write_probe(i, SC'($urandom));
        do_scan(12, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                write_probe(int'($urandom_range(0, NP - 1)), SC'($urandom));
            cnt = int'($urandom_range(0, 15));
            do_scan(cnt, (cnt > 0) && (r % 2 == 1));
        end

        // Write during scan is dropped; the rescan must show the old slot 0.
        do_scan(3, 1'b1);
        do_scan(1, 1'b0);

        // Abort together with start in idle does nothing.
        abort = 1'b1; start = 1'b1; probe_count = 4'd4;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);
        chk("abort_start_rv", 64'(result_valid), 64'd1);
        repeat (8) @(posedge clk);
        #1;

        // Abort during the capture of the second probe.
        h0 = |(fcmp(model[0]) & 32'h7FFF_FFFF);
        probe_count = 4'd4; start = 1'b1; nref_seen = 0;
        @(posedge clk); #1;
        start = 1'b0; k = cyc;
        for (int i = 0; i < 2; i++) begin
            ref_t re;
            re.chk = model[i]; re.cyc = k + SETTLE + i * (SETTLE + 2);
            ref_q.push_back(re);
        end
        seen = 0;
        for (int t = 0; t < 50 && seen < 2; t++) begin
            @(negedge clk);
            if (refresh) seen++;
        end
        chk("abort_wait_refresh", 64'(seen), 64'd2);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_rv", 64'(result_valid), 64'd0);
        chk("abort_probe0_hit", 64'(probe_hits[0]), 64'(h0));
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (refresh) seen++;
        end
        chk("abort_no_refresh", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Reset during capture clears everything, including the table.
        probe_count = 4'd3; start = 1'b1; nref_seen = 0;
        @(posedge clk); #1;
        start = 1'b0; k = cyc;
        begin
            ref_t re;
            re.chk = model[0]; re.cyc = k + SETTLE;
            ref_q.push_back(re);
        end
        seen = 0;
        for (int t = 0; t < 50 && seen < 1; t++) begin
            @(negedge clk);
            if (refresh) seen++;
        end
        chk("reset_wait_refresh", 64'(seen), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        reset = 1'b0;
        ref_q.delete(); cmp_q.delete();
        for (int i = 0; i < NP; i++) model[i] = '0;
        @(posedge clk); #1;
        do_scan(8, 1'b0);

        chk("ref_q_empty", 64'(ref_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
